// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: default widths,
// FSM state encoding and the word-alignment width.
package pc_fetch_ctrl_pkg;

  localparam int PC_ADDR_W  = 32;
  localparam int PC_INST_W  = 32;
  localparam int ALIGN_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_perf.sv
// Delivered/dropped instruction-word counters for the fetch controller.
// Both counters wrap and clear on reset.
module pc_fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        drop_inc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (fetch_inc) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop_inc)  perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, fetches words from memory and
// holds each one for IF/ID. Optional counters under PC_FETCH_CTRL_PERF_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = PC_ADDR_W,
  parameter int                INST_W   = PC_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              stall_id,
  input  logic              stall_mem,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_done,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              if_id_flush,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state_dbg
`ifdef PC_FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  // Handshake: a request holds mem_req/mem_addr until the cycle mem_ready=1
  // (transfer on that edge); exactly one mem_done later returns the word.
  // An instruction is consumed on any rising edge with inst_valid=1 and stall_id=0.

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc_n, drop_target, drop_target_n, mem_addr_n, inst_pc_n;
  logic [INST_W-1:0] inst_n;
  logic              drop, drop_n, inst_valid_n, mem_req_n;
  logic [ADDR_W-1:0] target;

  assign target      = {redirect_addr[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign if_id_flush = redirect_en;
  assign state_dbg   = state;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    drop_n        = drop;
    drop_target_n = drop_target;
    inst_valid_n  = inst_valid;
    inst_n        = inst;
    inst_pc_n     = inst_pc;
    case (state)
      ST_IDLE: begin
        if (redirect_en) pc_n = target;
        if (!stall_mem) state_n = ST_REQ;
      end
      ST_REQ: begin
        // The request in flight is never withdrawn; the redirect is deferred.
        if (redirect_en) begin
          drop_n        = 1'b1;
          drop_target_n = target;
        end
        if (mem_ready) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_done) begin
          if (drop || redirect_en) begin
            pc_n    = redirect_en ? target : drop_target;
            drop_n  = 1'b0;
            state_n = stall_mem ? ST_IDLE : ST_REQ;
          end else begin
            inst_n       = mem_rdata;
            inst_pc_n    = pc;
            inst_valid_n = 1'b1;
            pc_n         = pc + ADDR_W'(4);
            state_n      = ST_HOLD;
          end
        end else if (redirect_en) begin
          drop_n        = 1'b1;
          drop_target_n = target;
        end
      end
      ST_HOLD: begin
        if (redirect_en || !stall_id) begin
          if (redirect_en) pc_n = target;
          inst_valid_n = 1'b0;
          state_n      = stall_mem ? ST_IDLE : ST_REQ;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    mem_req_n  = (state_n == ST_REQ);
    mem_addr_n = (state_n == ST_REQ) ? pc_n : mem_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      drop        <= 1'b0;
      drop_target <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      mem_req     <= mem_req_n;
      mem_addr    <= mem_addr_n;
      inst_valid  <= inst_valid_n;
      inst        <= inst_n;
      inst_pc     <= inst_pc_n;
      drop        <= drop_n;
      drop_target <= drop_target_n;
    end
  end

`ifdef PC_FETCH_CTRL_PERF_EN
  logic wait_done, fetch_inc, drop_inc;

  always_comb begin
    wait_done = (state == ST_WAIT) && mem_done;
    fetch_inc = wait_done && !(drop || redirect_en);
    drop_inc  = wait_done && (drop || redirect_en);
  end

  pc_fetch_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_inc      (fetch_inc),
    .drop_inc       (drop_inc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
  );
`else
  // Counters are not built in this configuration.
`endif

endmodule
